ov5640_dvp_capture: RTL and testbench
=====================================

// Module: ov5640_dvp_capture
// PURPOSE
//  Receive side of the OV5640 camera link. The camera is clocked by ov5640_xclk from the
//  clock generator, and this block accepts the camera's returning DVP bus.
//  - Oversamples cam_pclk/href/vsync/data in the sys_clk domain.
//  - Assembles RGB565 pixels from byte pairs and presents them with a valid/ready handshake
//    to the frame-buffer writer.
//  - Flags overflow and malformed lines.
// PARAMETERS
//  H_ACTIVE     640  pixels per line; pix_eol asserts on pixel x==H_ACTIVE-1
//  SYNC_STAGES  2    synchroniser depth, applied to all DVP inputs (>=2)
// PORTS
//  sys_clk     in   1   sole clock; must be >= 4x cam_pclk
//  sys_rst     in   1   synchronous, active-high reset
//  enable      in   1   capture enable; sampled only at frame boundaries
//  cam_pclk    in   1   camera pixel clock (asynchronous; treated as data)
//  cam_vsync   in   1   frame sync, active high between frames
//  cam_href    in   1   line valid, active high
//  cam_data    in   8   DVP byte
//  pix_data    out  16  RGB565 pixel; first byte of the pair is [15:8]
//  pix_valid   out  1   pixel available; held with pix_data stable until pix_ready
//  pix_ready   in   1   downstream accept
//  pix_sof     out  1   qualifies pix_data: first pixel of the frame
//  pix_eol     out  1   qualifies pix_data: last pixel of the line
//  overflow    out  1   sticky: a pixel was dropped because the holding register was full
//  line_err    out  1   sticky: href fell with an odd byte, or the line exceeded H_ACTIVE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, byte phase=0, x counter=0, sticky flags cleared.
//  Sampling
//   - Every DVP input passes through the same SYNC_STAGES flops.
//   - pclk_rise = synced pclk 0->1. Byte capture happens only on pclk_rise with synced href=1.
//  FSM
//   - IDLE: when enable=1 and vsync rises -> WAIT_SOF.
//   - WAIT_SOF: when vsync falls -> ACTIVE. Set sof_pend=1, x=0, phase=0.
//   - ACTIVE:
//     - On vsync rise: if enable=1 -> WAIT_SOF, else -> IDLE.
//     - An incomplete pixel is discarded and line_err is set if phase=1.
//  Pixel assembly (ACTIVE only)
//   - phase=0: latch byte into hi, set phase=1.
//   - phase=1: form {hi,byte}, set phase=0.
//   - Pixel valid at pix_valid SYNC_STAGES+2 sys_clk after the second byte's pclk edge.
//  Line handling
//   - href falling edge: if phase=1, drop the byte and set line_err; then x=0, phase=0.
//   - Pixels with x>=H_ACTIVE are dropped and line_err is set. x saturates; it does not wrap.
//  Handshake (single holding register)
//   - Transfer when pix_valid&pix_ready. pix_valid drops the next cycle unless a new pixel
//     loads in that same cycle.
//   - New pixel while pix_valid&!pix_ready: drop the new pixel, set overflow,
//     keep the held pixel.
//   - New pixel in the same cycle as a transfer: load the new pixel, no overflow.
//  pix_sof = sof_pend at load time; sof_pend clears when the pixel loads.
//  sys_rst during a frame: capture is abandoned and the FSM returns to IDLE.
//   The next frame is captured only after a full vsync pulse.
//  enable=0 never truncates a frame in progress.
// CONFIGURATION
//  OV5640_CAPTURE_STATS_EN defined:
//   - Adds out[15:0] frame_cnt, incremented when ACTIVE->WAIT_SOF/IDLE; wraps at 0xFFFF.
//   - Adds out[11:0] line_cnt, lines seen in the last completed frame; saturates at 0xFFF.
//   - Both reset to 0.
//  OV5640_CAPTURE_STATS_EN undefined: those ports and counters are absent.
//   Behaviour is otherwise identical.
// STRUCTURE
//  Package ov5640_pkg: FSM state encoding (IDLE/WAIT_SOF/ACTIVE), DVP_W=8, PIX_W=16,
//   default H_ACTIVE.
//  Sub-module dvp_sync: SYNC_STAGES synchroniser for {pclk,vsync,href,data[7:0]}, plus
//   pclk_rise, href_fall, vsync_rise and vsync_fall pulses.
// TESTING
//  1. Frame: vsync pulse, then 2 lines of 640 px, ready=1; bytes 0xAB,0xCD per pixel
//     -> 1280 pixels of 0xABCD; sof on pixel 0 only; eol on pixels 639 and 1279.
//  2. Backpressure: ready=0 for 3 pixels -> first pixel held stable, overflow=1,
//     pixels 2-3 lost. Then ready=1 -> held pixel transfers exactly once.
//  3. Odd line: href falls after 3 bytes -> one pixel out, line_err=1, x reset;
//     the next line starts at x=0.
//  4. Long line: 642 px -> 640 pixels out, eol on pixel 639, line_err=1.
//  5. enable dropped mid-frame -> the frame completes; next vsync -> IDLE,
//     no pixels from the following frame.
//  6. sys_rst asserted mid-line -> all outputs 0 the next cycle; capture resumes only
//     after the next vsync rise then fall. With the stats macro, frame_cnt=0 after reset.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 DVP capture path.
// Optional statistics counters are enabled with `define OV5640_CAPTURE_STATS_EN.
package ov5640_pkg;

    localparam int DVP_W               = 8;
    localparam int PIX_W               = 16;
    localparam int H_ACTIVE_DEFAULT    = 640;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Capture FSM: waiting for a frame, inside the vsync pulse, or receiving lines.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } cap_state_t;

    // One sample of the camera bus, kept together so every bit sees the same delay.
    typedef struct packed {
        logic             pclk;
        logic             vsync;
        logic             href;
        logic [DVP_W-1:0] data;
    } dvp_bus_t;

    // RGB565 arrives big-endian: the first byte of a pair is the upper half.
    function automatic logic [PIX_W-1:0] rgb565_pack(input logic [DVP_W-1:0] hi,
                                                     input logic [DVP_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/ov5640_dvp_sync.sv
// Brings the asynchronous DVP bus into the sys_clk domain. pclk is treated as
// data: all eleven bits share one synchroniser so byte and strobe stay aligned.
// Edge pulses and level outputs are registered once more, so they are mutually
// aligned and glitch-free for the capture logic.
module dvp_sync
    import ov5640_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT   // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [DVP_W-1:0] cam_data,
    output logic             href,
    output logic [DVP_W-1:0] data,
    output logic             pclk_rise,
    output logic             href_fall,
    output logic             vsync_rise,
    output logic             vsync_fall
);

    dvp_bus_t                   bus_in;
    dvp_bus_t [SYNC_STAGES-1:0] sync_q;
    dvp_bus_t                   prev_q;
    dvp_bus_t                   bus_s;

    assign bus_in.pclk  = cam_pclk;
    assign bus_in.vsync = cam_vsync;
    assign bus_in.href  = cam_href;
    assign bus_in.data  = cam_data;
    assign bus_s        = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one-cycle history of its output for edge detection.
    // NOTE: these flops are deliberately not reset; they always track the live bus,
    // so releasing reset can never fabricate a vsync/href/pclk edge.
    // NOTE: non-blocking assignments make the shift register shift by exactly one
    // stage per clock regardless of statement order.
    always_ff @(posedge clk) begin
        sync_q[0] <= bus_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
        prev_q <= bus_s;
    end

    // Registered edge pulses and levels, all valid in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            href       <= 1'b0;
            data       <= '0;
            pclk_rise  <= 1'b0;
            href_fall  <= 1'b0;
            vsync_rise <= 1'b0;
            vsync_fall <= 1'b0;
        end else begin
            href       <= bus_s.href;
            data       <= bus_s.data;
            pclk_rise  <= bus_s.pclk  & ~prev_q.pclk;
            href_fall  <= ~bus_s.href & prev_q.href;
            vsync_rise <= bus_s.vsync & ~prev_q.vsync;
            vsync_fall <= ~bus_s.vsync & prev_q.vsync;
        end
    end

endmodule

// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP receive path: oversampled capture, RGB565 assembly, single-entry
// valid/ready output register, sticky overflow and line-error flags.
// `define OV5640_CAPTURE_STATS_EN adds frame_cnt and line_cnt outputs.
module ov5640_dvp_capture
    import ov5640_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [DVP_W-1:0] cam_data,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             overflow,
    output logic             line_err
`ifdef OV5640_CAPTURE_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [11:0]      line_cnt
`endif
);

    localparam int             X_W    = $clog2(H_ACTIVE + 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] X_SAT  = X_W'(H_ACTIVE);

    // Synchronised camera bus
    logic             s_href;
    logic [DVP_W-1:0] s_data;
    logic             pclk_rise;
    logic             href_fall;
    logic             vsync_rise;
    logic             vsync_fall;

    // FSM
    cap_state_t state;
    cap_state_t state_nxt;
    logic       in_active;
    logic       frame_start;
    logic       frame_end;

    // Pixel assembly
    logic             phase;
    logic [DVP_W-1:0] hi_q;
    logic [X_W-1:0]   x_q;
    logic             sof_pend;
    logic             byte_cap;
    logic             pix_done;
    logic             in_range;
    logic             new_pix;
    logic             accept;
    logic             load;

    dvp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .href       (s_href),
        .data       (s_data),
        .pclk_rise  (pclk_rise),
        .href_fall  (href_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall)
    );

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // FSM next state: enable is only consulted on a vsync rise, so a frame in
    // progress always runs to completion.
    // NOTE: state_nxt defaults to the current state before any branch, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (enable && vsync_rise) state_nxt = ST_WAIT_SOF;
            ST_WAIT_SOF: if (vsync_fall)           state_nxt = ST_ACTIVE;
            ST_ACTIVE:   if (vsync_rise)           state_nxt = enable ? ST_WAIT_SOF : ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: capture window and frame boundary strobes.
    always_comb begin
        in_active   = (state == ST_ACTIVE);
        frame_start = (state == ST_WAIT_SOF) && vsync_fall;
        frame_end   = (state == ST_ACTIVE)   && vsync_rise;
    end

    // A byte is taken on each synced pclk rise while href is high; the second
    // byte of a pair completes a pixel, which is kept only if x is on-screen.
    assign byte_cap = in_active && !frame_end && pclk_rise && s_href;
    assign pix_done = byte_cap && phase;
    assign in_range = (x_q != X_SAT);
    assign new_pix  = pix_done && in_range;
    assign accept   = !pix_valid || pix_ready;
    assign load     = new_pix && accept;

    // Byte phase, high byte, x position and start-of-frame marker.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            phase    <= 1'b0;
            hi_q     <= '0;
            x_q      <= '0;
            sof_pend <= 1'b0;
        end else if (frame_start) begin
            phase    <= 1'b0;
            x_q      <= '0;
            sof_pend <= 1'b1;
        end else if (in_active) begin
            if (frame_end || href_fall) begin
                phase <= 1'b0;
                if (href_fall) x_q <= '0;
            end else if (byte_cap) begin
                if (!phase) begin
                    hi_q  <= s_data;
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (in_range) x_q <= x_q + 1'b1;
                end
            end
            if (load) sof_pend <= 1'b0;
        end
    end

    // Single holding register; a pixel arriving while it is full and stalled is dropped.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
        end else if (load) begin
            pix_valid <= 1'b1;
            pix_data  <= rgb565_pack(hi_q, s_data);
            pix_sof   <= sof_pend;
            pix_eol   <= (x_q == X_LAST);
        end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            overflow <= 1'b0;
            line_err <= 1'b0;
        end else begin
            if (new_pix && !accept) overflow <= 1'b1;
            if (in_active && phase && (href_fall || frame_end)) line_err <= 1'b1;
            if (pix_done && !in_range) line_err <= 1'b1;
        end
    end

`ifdef OV5640_CAPTURE_STATS_EN
    logic [11:0] line_run;

    // Frame and line statistics; line_cnt publishes the count of the frame just ended.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt <= '0;
            line_cnt  <= '0;
            line_run  <= '0;
        end else begin
            if (frame_start) begin
                line_run <= '0;
            end else if (in_active && href_fall && line_run != 12'hFFF) begin
                line_run <= line_run + 12'd1;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
                line_cnt  <= line_run;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Directed bench for ov5640_dvp_capture: full frame, backpressure, odd and long
// lines, enable gating and mid-line reset. Stats checks follow
// `define OV5640_CAPTURE_STATS_EN.
module tb_ov5640_dvp_capture;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        enable    = 1'b0;
    logic        cam_pclk  = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href  = 1'b0;
    logic [7:0]  cam_data  = 8'h00;
    logic        pix_ready = 1'b0;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_eol;
    logic        overflow;
    logic        line_err;
`ifdef OV5640_CAPTURE_STATS_EN
    logic [15:0] frame_cnt;
    logic [11:0] line_cnt;
`endif

    int passed = 0;
    int total  = 0;

    // Transfer monitor state (written only by the monitor process)
    int          xfer_cnt = 0;
    int          bad_cnt  = 0;
    int          hold_chg = 0;
    int          sof_q[$];
    int          eol_q[$];
    logic        held_prev = 1'b0;
    logic [15:0] held_data = 16'h0;

    // Expected word for transferred pixels (written only by the stimulus)
    logic        chk_en   = 1'b0;
    logic [15:0] exp_word = 16'h0;

    ov5640_dvp_capture dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .enable    (enable),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .overflow  (overflow),
        .line_err  (line_err)
`ifdef OV5640_CAPTURE_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .line_cnt  (line_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Records every handshake; pix_ready only changes mid-way between posedge and negedge.
    always @(negedge sys_clk) begin
        if (!sys_rst && pix_valid) begin
            if (held_prev && pix_data !== held_data) hold_chg++;
            if (pix_ready) begin
                if (chk_en && pix_data !== exp_word) bad_cnt++;
                if (pix_sof) sof_q.push_back(xfer_cnt);
                if (pix_eol) eol_q.push_back(xfer_cnt);
                xfer_cnt++;
                held_prev = 1'b0;
            end else begin
                held_prev = 1'b1;
                held_data = pix_data;
            end
        end else begin
            held_prev = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge sys_clk);
        #2 pix_ready = v;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        #150 cam_vsync = 1'b0;
        #150;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        #30 cam_pclk = 1'b1;
        #30 cam_pclk = 1'b0;
    endtask

    // Line of nbytes bytes alternating w[15:8], w[7:0].
    task automatic send_line(input int nbytes, input logic [15:0] w);
        cam_href = 1'b1;
        #30;
        for (int i = 0; i < nbytes; i++) send_byte((i % 2) ? w[7:0] : w[15:8]);
        #30 cam_href = 1'b0;
        #150;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (pix_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pix_valid); else passed++;
        total++; if (pix_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", pix_data); else passed++;
        total++; if ({pix_sof, pix_eol, overflow, line_err} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {pix_sof, pix_eol, overflow, line_err}); else passed++;
    endtask

    task automatic test_frame();
        int base, b0, s0, e0, s_idx, e_a, e_b;
        apply_reset();
        enable = 1'b1;
        set_ready(1'b1);
        chk_en = 1'b1; exp_word = 16'hABCD;
        base = xfer_cnt; b0 = bad_cnt; s0 = sof_q.size(); e0 = eol_q.size();
        vsync_pulse();
        send_line(1280, 16'hABCD);
        send_line(1280, 16'hABCD);
        s_idx = (sof_q.size() > s0)     ? sof_q[s0] - base     : -1;
        e_a   = (eol_q.size() > e0)     ? eol_q[e0] - base     : -1;
        e_b   = (eol_q.size() > e0 + 1) ? eol_q[e0 + 1] - base : -1;
        total++; if (xfer_cnt - base !== 1280) $display("FAIL frame_pixels: got %0d want 1280", xfer_cnt - base); else passed++;
        total++; if (bad_cnt - b0 !== 0) $display("FAIL frame_data: got %0d bad words want 0", bad_cnt - b0); else passed++;
        total++; if (sof_q.size() - s0 !== 1) $display("FAIL frame_sof_count: got %0d want 1", sof_q.size() - s0); else passed++;
        total++; if (s_idx !== 0) $display("FAIL frame_sof_index: got %0d want 0", s_idx); else passed++;
        total++; if (eol_q.size() - e0 !== 2) $display("FAIL frame_eol_count: got %0d want 2", eol_q.size() - e0); else passed++;
        total++; if (e_a !== 639) $display("FAIL frame_eol_first: got %0d want 639", e_a); else passed++;
        total++; if (e_b !== 1279) $display("FAIL frame_eol_second: got %0d want 1279", e_b); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL frame_overflow: got %b want 0", overflow); else passed++;
        total++; if (line_err !== 1'b0) $display("FAIL frame_line_err: got %b want 0", line_err); else passed++;
    endtask

    task automatic test_backpressure();
        int base, b0, h0;
        apply_reset();
        enable = 1'b1;
        set_ready(1'b0);
        chk_en = 1'b1; exp_word = 16'h1122;
        base = xfer_cnt; b0 = bad_cnt; h0 = hold_chg;
        vsync_pulse();
        cam_href = 1'b1;
        #30;
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        #30 cam_href = 1'b0;
        #150;
        repeat (5) @(negedge sys_clk);
        total++; if (pix_valid !== 1'b1) $display("FAIL bp_valid_held: got %b want 1", pix_valid); else passed++;
        total++; if (pix_data !== 16'h1122) $display("FAIL bp_data_held: got %h want 1122", pix_data); else passed++;
        total++; if (pix_sof !== 1'b1) $display("FAIL bp_sof_held: got %b want 1", pix_sof); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL bp_overflow: got %b want 1", overflow); else passed++;
        total++; if (xfer_cnt - base !== 0) $display("FAIL bp_no_xfer: got %0d want 0", xfer_cnt - base); else passed++;
        set_ready(1'b1);
        repeat (5) @(negedge sys_clk);
        total++; if (xfer_cnt - base !== 1) $display("FAIL bp_single_xfer: got %0d want 1", xfer_cnt - base); else passed++;
        total++; if (bad_cnt - b0 !== 0) $display("FAIL bp_xfer_data: got %0d bad words want 0", bad_cnt - b0); else passed++;
        total++; if (pix_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", pix_valid); else passed++;
        total++; if (hold_chg - h0 !== 0) $display("FAIL bp_stable: got %0d changes want 0", hold_chg - h0); else passed++;
    endtask

    task automatic test_odd_line();
        int base, b0, e0, e_a;
        apply_reset();
        enable = 1'b1;
        set_ready(1'b1);
        chk_en = 1'b1; exp_word = 16'hABCD;
        base = xfer_cnt; b0 = bad_cnt; e0 = eol_q.size();
        vsync_pulse();
        send_line(3, 16'hABCD);
        total++; if (line_err !== 1'b1) $display("FAIL odd_line_err: got %b want 1", line_err); else passed++;
        total++; if (xfer_cnt - base !== 1) $display("FAIL odd_one_pixel: got %0d want 1", xfer_cnt - base); else passed++;
        send_line(1280, 16'hABCD);
        e_a = (eol_q.size() > e0) ? eol_q[e0] - base : -1;
        total++; if (xfer_cnt - base !== 641) $display("FAIL odd_total: got %0d want 641", xfer_cnt - base); else passed++;
        total++; if (e_a !== 640) $display("FAIL odd_next_line_x0: eol at %0d want 640", e_a); else passed++;
        total++; if (bad_cnt - b0 !== 0) $display("FAIL odd_data: got %0d bad words want 0", bad_cnt - b0); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL odd_overflow: got %b want 0", overflow); else passed++;
    endtask

    task automatic test_long_line();
        int base, e0, e_a;
        apply_reset();
        enable = 1'b1;
        set_ready(1'b1);
        chk_en = 1'b1; exp_word = 16'h07E0;
        base = xfer_cnt; e0 = eol_q.size();
        vsync_pulse();
        send_line(1284, 16'h07E0);
        e_a = (eol_q.size() > e0) ? eol_q[e0] - base : -1;
        total++; if (xfer_cnt - base !== 640) $display("FAIL long_pixels: got %0d want 640", xfer_cnt - base); else passed++;
        total++; if (eol_q.size() - e0 !== 1) $display("FAIL long_eol_count: got %0d want 1", eol_q.size() - e0); else passed++;
        total++; if (e_a !== 639) $display("FAIL long_eol_index: got %0d want 639", e_a); else passed++;
        total++; if (line_err !== 1'b1) $display("FAIL long_line_err: got %b want 1", line_err); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL long_overflow: got %b want 0", overflow); else passed++;
    endtask

    task automatic test_enable_drop();
        int base, s0, s_idx;
        apply_reset();
        enable = 1'b1;
        set_ready(1'b1);
        chk_en = 1'b1; exp_word = 16'hF800;
        base = xfer_cnt;
        vsync_pulse();
        enable = 1'b0;
        send_line(8, 16'hF800);
        total++; if (xfer_cnt - base !== 4) $display("FAIL en_frame_completes: got %0d want 4", xfer_cnt - base); else passed++;
        vsync_pulse();
        send_line(8, 16'hF800);
`ifdef OV5640_CAPTURE_STATS_EN
        total++; if (frame_cnt !== 16'd1) $display("FAIL en_frame_cnt: got %0d want 1", frame_cnt); else passed++;
        total++; if (line_cnt !== 12'd1) $display("FAIL en_line_cnt: got %0d want 1", line_cnt); else passed++;
`endif
        vsync_pulse();
        send_line(8, 16'hF800);
        total++; if (xfer_cnt - base !== 4) $display("FAIL en_idle_no_pixels: got %0d want 4", xfer_cnt - base); else passed++;
        enable = 1'b1;
        s0 = sof_q.size();
        vsync_pulse();
        send_line(4, 16'hF800);
        s_idx = (sof_q.size() > s0) ? sof_q[s0] - base : -1;
        total++; if (xfer_cnt - base !== 6) $display("FAIL en_resume: got %0d want 6", xfer_cnt - base); else passed++;
        total++; if (s_idx !== 4) $display("FAIL en_resume_sof: got %0d want 4", s_idx); else passed++;
    endtask

    task automatic test_sys_rst();
        int base, s0, s_idx;
        apply_reset();
        enable = 1'b1;
        set_ready(1'b0);
        chk_en = 1'b1; exp_word = 16'h1234;
        vsync_pulse();
        cam_href = 1'b1;
        #30;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h12);
        repeat (5) @(negedge sys_clk);
        total++; if ({pix_valid, overflow} !== 2'b11) $display("FAIL rst_pre_state: got %b want 11", {pix_valid, overflow}); else passed++;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        total++; if ({pix_valid, pix_data, pix_sof, pix_eol, overflow, line_err} !== 21'h0)
            $display("FAIL rst_outputs: got %h want 0", {pix_valid, pix_data, pix_sof, pix_eol, overflow, line_err}); else passed++;
`ifdef OV5640_CAPTURE_STATS_EN
        total++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); else passed++;
`endif
        sys_rst = 1'b0;
        set_ready(1'b1);
        base = xfer_cnt;
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h34);
        #30 cam_href = 1'b0;
        #150;
        send_line(4, 16'h1234);
        total++; if (xfer_cnt - base !== 0) $display("FAIL rst_no_capture: got %0d want 0", xfer_cnt - base); else passed++;
        s0 = sof_q.size();
        vsync_pulse();
        send_line(4, 16'h1234);
        s_idx = (sof_q.size() > s0) ? sof_q[s0] - base : -1;
        total++; if (xfer_cnt - base !== 2) $display("FAIL rst_resume: got %0d want 2", xfer_cnt - base); else passed++;
        total++; if (s_idx !== 0) $display("FAIL rst_resume_sof: got %0d want 0", s_idx); else passed++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_odd_line();
        test_long_line();
        test_enable_drop();
        test_sys_rst();
        total++; if (bad_cnt !== 0) $display("FAIL data_overall: got %0d bad words want 0", bad_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
